// File: rtl/ula32_serial.sv
// Digit-serial 32-bit ALU: one DIGIT-wide slice iterated WIDTH/DIGIT times,
// with valid/ready handshakes on the request and result sides.
module ula32_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ula_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             add_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ula_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = WIDTH - DIGIT;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [RW-1:0]    res_q, res_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d, zero_q, zero_d;

  logic [DIGIT-1:0] a_dig, b_dig, dig_res;
  logic [DIGIT:0]   sum;
  logic             ovf_dig, fin_ovf, inv;
  logic [WIDTH-1:0] full_res, fin_res;

  // B already holds ~B for SUB/SLT, so the MSB-digit overflow test is the plain add rule.
  always_comb begin
    a_dig   = a_q[DIGIT-1:0];
    b_dig   = b_q[DIGIT-1:0];
    sum     = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    ovf_dig = (a_dig[DIGIT-1] == b_dig[DIGIT-1]) && (sum[DIGIT-1] != a_dig[DIGIT-1]);
    case (op_q)
      3'b000:  dig_res = a_dig & b_dig;
      3'b001:  dig_res = a_dig | b_dig;
      3'b010:  dig_res = sum[DIGIT-1:0];
      3'b011:  dig_res = sum[DIGIT-1:0];
      3'b100:  dig_res = a_dig ^ b_dig;
      3'b101:  dig_res = ~(a_dig | b_dig);
      default: dig_res = '0;
    endcase
    full_res = {dig_res, res_q};
    if (op_q == 3'b011) fin_res = {{(WIDTH-1){1'b0}}, sum[DIGIT-1] ^ ovf_dig};
    else                fin_res = full_res;
    fin_ovf = (op_q == 3'b010) && ovf_dig;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    op_d    = op_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    inv     = ((ula_ctrl == 3'b010) && add_sub) || (ula_ctrl == 3'b011);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = ula_ctrl;
          a_d     = src_a;
          b_d     = inv ? ~src_b : src_b;
          carry_d = inv;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = sum[DIGIT];
        res_d   = {dig_res, res_q[RW-1:DIGIT]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          out_d   = fin_res;
          ovf_d   = fin_ovf;
          zero_d  = (fin_res == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 3'b000;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ula_out   = out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_ula32_serial.sv
// Scoreboard bench for ula32_serial: a driver pushes model results on accept,
// a monitor pops and compares whenever a result is handed over.
module tb_ula32_serial;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    int          acc;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [2:0]  ctrl = 3'b000;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        addSub = 1'b0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] ulaOut;
  logic        ovf;
  logic        zeroFlag;

  expT scoreboard[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  randomBp = 1'b0;
  bit  prevValid = 1'b0;

  ula32_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .ula_ctrl(ctrl), .src_a(srcA), .src_b(srcB), .add_sub(addSub),
    .out_valid(outValid), .out_ready(outReady), .ula_out(ulaOut),
    .overflow(ovf), .zero(zeroFlag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference model: whole-word signed arithmetic, no digit iteration.
  function automatic expT model(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic as);
    expT    e;
    longint sa, sb, s;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.ovf = 1'b0;
    e.acc = 0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        s     = as ? (sa - sb) : (sa + sb);
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd3: e.res = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: e.res = a ^ b;
      3'd5: e.res = ~(a | b);
      default: e.res = 32'd0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic as);
    expT e;
    int  waited;
    ctrl    = op;
    srcA    = a;
    srcB    = b;
    addSub  = as;
    inValid = 1'b1;
    waited  = 0;
    @(negedge clk);
    while (!inReady && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!inReady) begin
      checkOutput("accept timeout", 32'(inReady), 32'd1);
      inValid = 1'b0;
      return;
    end
    e     = model(op, a, b, as);
    e.acc = cyc + 1;
    scoreboard.push_back(e);
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (scoreboard.size() != 0 && waited < 400) begin
      @(posedge clk);
      waited++;
    end
    if (scoreboard.size() != 0) checkOutput("drain timeout", 32'(scoreboard.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on the rising edge of out_valid, contents on each handover.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (outValid && !prevValid && scoreboard.size() != 0)
        checkOutput("latency", 32'(cyc - scoreboard[0].acc), 32'(N));
      if (outValid && outReady) begin
        if (scoreboard.size() == 0) begin
          checkOutput("unexpected result", 32'd1, 32'd0);
        end else begin
          e = scoreboard.pop_front();
          checkOutput("result", ulaOut, e.res);
          checkOutput("overflow", 32'(ovf), 32'(e.ovf));
          checkOutput("zero", 32'(zeroFlag), 32'(e.zero));
        end
      end
      prevValid = outValid;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randomBp) outReady = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] corners [6];
    logic [31:0] heldOut;
    logic        heldOvf, heldZero, sawValid;
    logic [31:0] ra, rb;
    int          waited;
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h5};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset in_ready", 32'(inReady), 32'd1);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset ula_out", ulaOut, 32'd0);
    checkOutput("reset overflow", 32'(ovf), 32'd0);
    checkOutput("reset zero", 32'(zeroFlag), 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(3'b010, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    waitDrain();
    checkOutput("add max hold", ulaOut, 32'h80000000);
    checkOutput("add max ovf", 32'(ovf), 32'd1);
    applyStimulus(3'b010, 32'd5, 32'd5, 1'b1);
    applyStimulus(3'b010, 32'h80000000, 32'd1, 1'b1);
    waitDrain();
    checkOutput("sub min hold", ulaOut, 32'h7FFFFFFF);
    applyStimulus(3'b011, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    applyStimulus(3'b011, 32'h7FFFFFFF, 32'h80000000, 1'b0);
    waitDrain();
    checkOutput("slt ovf hold", ulaOut, 32'd0);
    checkOutput("slt zero hold", 32'(zeroFlag), 32'd1);
    applyStimulus(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    waitDrain();
    checkOutput("and hold", ulaOut, 32'hF000F000);
    applyStimulus(3'b101, 32'd0, 32'd0, 1'b0);
    waitDrain();
    checkOutput("nor hold", ulaOut, 32'hFFFFFFFF);
    applyStimulus(3'b110, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    waitDrain();
    checkOutput("reserved hold", ulaOut, 32'd0);
    checkOutput("reserved zero", 32'(zeroFlag), 32'd1);

    // Backpressure: result held for 10 cycles while a stray request is offered.
    outReady = 1'b0;
    applyStimulus(3'b100, 32'hDEADBEEF, 32'h0F0F0F0F, 1'b0);
    waited = 0;
    @(negedge clk);
    while (!outValid && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    checkOutput("bp out_valid", 32'(outValid), 32'd1);
    heldOut  = ulaOut;
    heldOvf  = ovf;
    heldZero = zeroFlag;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        ctrl    = 3'b001;
        srcA    = 32'h11111111;
        inValid = 1'b1;
      end
      if (i == 5) inValid = 1'b0;
      checkOutput("bp stable out", ulaOut, heldOut);
      checkOutput("bp stable flags", {30'd0, ovf, zeroFlag}, {30'd0, heldOvf, heldZero});
      checkOutput("bp in_ready", 32'(inReady), 32'd0);
      checkOutput("bp valid held", 32'(outValid), 32'd1);
    end
    @(posedge clk);
    #1 outReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp release in_ready", 32'(inReady), 32'd1);
    checkOutput("bp release out_valid", 32'(outValid), 32'd0);
    repeat (20) @(posedge clk);
    #1;

    // Reset in the middle of RUN discards the operation.
    applyStimulus(3'b010, 32'd10, 32'd20, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    void'(scoreboard.pop_back());
    @(negedge clk);
    checkOutput("abort in_ready", 32'(inReady), 32'd1);
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("abort no valid", 32'(sawValid), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(3'b010, 32'd1, 32'd2, 1'b0);
    waitDrain();
    checkOutput("post reset add", ulaOut, 32'd3);

    randomBp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      applyStimulus(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
    end
    waitDrain();
    randomBp = 1'b0;
    outReady = 1'b1;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
